ir_beacon_tx: RTL and testbench

// - IR beacon transmitter: the emitting end of the IR frequency link the robot decodes. Drives an IR LED

---
 rtl/ir_beacon_tx.sv | 170 +++++++++++++++++
 tb/tb_ir_beacon_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: 50%-duty carrier at a programmable frequency in Hz,
// half-period from a serial restoring divider, with optional on/off burst keying.
module ir_beacon_tx #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned BURST_CYC = 2_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] freq_hz,
   input  logic       load,
   input  logic       enable,
   input  logic       burst_en,
   output logic       ir_out,
   output logic       busy,
   output logic       ready,
   output logic       err
);

   localparam int unsigned FREQ_W = 10;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned STEP_W = 6;
   localparam logic [CNT_W-1:0]  DIVIDEND   = CNT_W'(CLK_HZ / 2);
   localparam logic [CNT_W-1:0]  BURST_LEN  = CNT_W'(BURST_CYC);
   localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(2 * BURST_CYC - 1);
   localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(32);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIVIDE,
      ST_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [FREQ_W-1:0]   div_q, div_d;
   logic [FREQ_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]    quo_q, quo_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [CNT_W-1:0]    half_q, half_d;
   logic [CNT_W-1:0]    car_q, car_d;
   logic [CNT_W-1:0]    burst_q, burst_d;
   logic                phase_q, phase_d;
   logic                ir_q, ir_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   logic                start_c;
   logic [FREQ_W:0]     rem_sh_c;
   logic                ge_c;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         step_q  <= '0;
         half_q  <= '0;
         car_q   <= '0;
         burst_q <= '0;
         phase_q <= 1'b0;
         ir_q    <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         step_q  <= step_d;
         half_q  <= half_d;
         car_q   <= car_d;
         burst_q <= burst_d;
         phase_q <= phase_d;
         ir_q    <= ir_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // Next-state: divider steps, carrier/burst counters, output decode
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      step_d   = step_q;
      half_d   = half_q;
      car_d    = car_q;
      burst_d  = burst_q;
      phase_d  = phase_q;
      ir_d     = 1'b0;
      busy_d   = busy_q;
      ready_d  = ready_q;
      err_d    = err_q;
      start_c  = 1'b0;
      rem_sh_c = {rem_q, quo_q[CNT_W-1]};
      ge_c     = (rem_sh_c >= {1'b0, div_q});

      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               if (freq_hz != '0) start_c = 1'b1;
               else               err_d   = 1'b1;
            end
         end
         ST_DIVIDE: begin
            if (step_q == LAST_STEP) begin
               half_d  = quo_q;
               state_d = ST_RUN;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               car_d   = '0;
               phase_d = 1'b0;
               burst_d = '0;
            end else begin
               rem_d  = ge_c ? FREQ_W'(rem_sh_c - {1'b0, div_q}) : FREQ_W'(rem_sh_c);
               quo_d  = {quo_q[CNT_W-2:0], ge_c};
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_RUN: begin
            if (load) begin
               ready_d = 1'b0;
               if (freq_hz != '0) begin
                  start_c = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (enable) begin
               if (car_q == half_q - CNT_W'(1)) begin
                  car_d   = '0;
                  phase_d = ~phase_q;
               end else begin
                  car_d = car_q + CNT_W'(1);
               end
               burst_d = (burst_q == BURST_LAST) ? '0 : burst_q + CNT_W'(1);
               ir_d    = phase_d & (~burst_en | (burst_d < BURST_LEN));
            end else begin
               // Disabled: hold at the RUN-entry point so re-enable restarts cleanly
               car_d   = '0;
               phase_d = 1'b0;
               burst_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_c) begin
         state_d = ST_DIVIDE;
         div_d   = freq_hz;
         rem_d   = '0;
         quo_d   = DIVIDEND;
         step_d  = '0;
         busy_d  = 1'b1;
         ready_d = 1'b0;
         err_d   = 1'b0;
      end
   end

   assign ir_out = ir_q;
   assign busy   = busy_q;
   assign ready  = ready_q;
   assign err    = err_q;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Randomized bench for ir_beacon_tx against a time-index reference model.
module tb_ir_beacon_tx;

   localparam int unsigned CLK_HZ    = 2000;
   localparam int unsigned BURST_CYC = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] freq_hz;
   logic       load;
   logic       enable;
   logic       burst_en;
   logic       ir_out;
   logic       busy;
   logic       ready;
   logic       err;

   ir_beacon_tx #(.CLK_HZ(CLK_HZ), .BURST_CYC(BURST_CYC)) dut (
      .clk      (clk),
      .reset    (reset),
      .freq_hz  (freq_hz),
      .load     (load),
      .enable   (enable),
      .burst_en (burst_en),
      .ir_out   (ir_out),
      .busy     (busy),
      .ready    (ready),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0=idle 1=divide 2=run; t = edges since load; n = enabled edges in run
   int          m_mode = 0;
   int          m_t    = 0;
   int          m_n    = 0;
   int unsigned m_lat  = 0;
   int unsigned m_q    = 0;
   logic        m_err  = 1'b0;

   int  cyc       = 0;
   logic prev_ir  = 1'b0;
   bit  meas_en   = 1'b0;
   int  last_rise = -1;
   int  period    = 0;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_mode = 0;
         m_err  = 1'b0;
         m_n    = 0;
      end else begin
         case (m_mode)
            0: if (load) begin
                  if (freq_hz != 0) begin m_mode = 1; m_t = 0; m_lat = freq_hz; m_err = 1'b0; end
                  else m_err = 1'b1;
               end
            1: begin
                  m_t++;
                  if (m_t == 33) begin m_mode = 2; m_q = (CLK_HZ / 2) / m_lat; m_n = 0; end
               end
            default: begin
                  if (load) begin
                     if (freq_hz != 0) begin m_mode = 1; m_t = 0; m_lat = freq_hz; m_err = 1'b0; end
                     else begin m_mode = 0; m_err = 1'b1; end
                  end else if (enable) m_n++;
                  else m_n = 0;
               end
         endcase
      end
   endtask

   function automatic logic exp_ir();
      logic p, on;
      if (m_mode != 2 || m_q == 0) return 1'b0;
      p  = ((m_n / m_q) % 2) == 1;
      on = (m_n % (2 * BURST_CYC)) < BURST_CYC;
      return p & (~burst_en | on);
   endfunction

   task automatic cycle();
      logic e_ir;
      @(posedge clk);
      model_update();
      e_ir = exp_ir();
      #1;
      cyc++;
      check("ir_out", ir_out, e_ir);
      check("busy",   busy,   m_mode == 1);
      check("ready",  ready,  m_mode == 2);
      check("err",    err,    m_err);
      if (meas_en && ir_out && !prev_ir) begin
         if (last_rise >= 0) period = cyc - last_rise;
         last_rise = cyc;
      end
      prev_ir = ir_out;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input int f);
      load = 1'b1; freq_hz = 10'(f);
      cycle();
      load = 1'b0; freq_hz = 10'($urandom_range(0, 1023));
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; freq_hz = '0; enable = 1'b0; burst_en = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         load = 1'($urandom); freq_hz = 10'($urandom); enable = 1'($urandom); burst_en = 1'($urandom);
         cycle();
      end
      reset = 1'b0; load = 1'b0; enable = 1'b1; burst_en = 1'b0;

      // 100 Hz with a load ignored mid-divide, then retune to 50 Hz
      do_load(100);
      run(5);
      do_load(50);
      run(27 + 80);
      do_load(50);
      run(33 + 120);

      // zero frequency sets err, a good load clears it
      do_load(0);
      run(5);
      do_load(100);
      run(33 + 50);

      // burst keying, disable mid-burst, re-enable
      burst_en = 1'b1;
      run(450);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(250);
      burst_en = 1'b0;

      // reset aborts an in-flight divide
      do_load(200);
      run(10);
      reset = 1'b1; cycle(); reset = 1'b0;
      run(40);

      // 3 Hz: long half-period, measure the carrier period
      do_load(3);
      run(33);
      meas_en = 1'b1;
      run(1500);
      meas_en = 1'b0;
      check("period_3hz", period, 666);

      // random traffic
      for (int i = 0; i < 15000; i++) begin
         reset = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 299) == 0) begin
            load    = 1'b1;
            freq_hz = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(20, 1023));
         end else begin
            load    = 1'b0;
            freq_hz = 10'($urandom);
         end
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         if ($urandom_range(0, 149) == 0) burst_en = ~burst_en;
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
